rcosc_freq_monitor: RTL
=======================

Name: rcosc_freq_monitor

Overview:
- Fabric-side consumer of the on-chip 1 MHz RC oscillator output (RCOSC_1MHZ_O2F).
- Samples the oscillator as asynchronous data in the system clock domain and measures its frequency over a fixed window of oscillator periods.
- Flags in-range, out-of-range and lost-clock conditions for the system controller and for IAP supervision logic.

Parameters:
- OSC_PERIODS, 16: oscillator rising edges per measurement window.
- COUNT_W, 16: width of the window and gap counters.
- EXP_MIN, 760: minimum acceptable CLK cycles per window (nominal 800 at 50 MHz CLK).
- EXP_MAX, 840: maximum acceptable CLK cycles per window.
- LOSS_TIMEOUT, 200: CLK cycles without an oscillator edge that declare the oscillator lost.

Ports:
- CLK, input, 1: system clock; sole clock of the block.
- RESETN, input, 1: reset; asynchronous assert, active-low.
- EN, input, 1: monitor enable, level-sensitive.
- OSC_IN, input, 1: RC oscillator output, asynchronous to CLK.
- MEAS_COUNT, output, COUNT_W: last completed window length in CLK cycles.
- MEAS_VALID, output, 1: one-cycle pulse when MEAS_COUNT updates.
- FREQ_OK, output, 1: last window was within [EXP_MIN, EXP_MAX].
- FREQ_ERR, output, 1: last window was out of range, or the oscillator is lost.
- CLK_LOST, output, 1: high while in the LOST state.

Behaviour:
- Clocking and reset: one clock, CLK; reset RESETN is asynchronous and active-low. All outputs and state reset to 0; FSM resets to IDLE.
- Input synchroniser: OSC_IN passes through a 2-FF synchroniser plus one delay FF. edge_p = sync2 & ~sync3, asserted 3 CLK cycles after an OSC_IN rise. Only rising edges are used.
- FSM states: IDLE, ARM, MEASURE, LOST.
- IDLE:
  - Entered when EN=0, from any state, on the next cycle.
  - Counters cleared; FREQ_OK, FREQ_ERR, CLK_LOST = 0; MEAS_COUNT holds its value.
  - EN=1 -> ARM.
- ARM:
  - Waits for the first edge_p.
  - edge_p -> MEASURE; that edge is the window start, edge_cnt=0, win_cnt cleared.
- MEASURE:
  - win_cnt counts CLK cycles since the start edge, saturating at 2^COUNT_W-1.
  - Each edge_p increments edge_cnt.
  - On the edge_p where edge_cnt reaches OSC_PERIODS (the terminal edge), MEAS_COUNT <= cycle distance from start edge to terminal edge. Ideal 50-cycle period gives 800.
  - MEAS_VALID pulses one cycle later, at the same time FREQ_OK/FREQ_ERR update. They are mutually exclusive and hold until the next update.
  - The terminal edge is also the start edge of the next window: no gap, no lost cycles.
  - A saturated count is always out of range, so FREQ_ERR=1.
- Loss detection:
  - gap_cnt counts cycles since the last edge_p in ARM and MEASURE, and is cleared by every edge_p.
  - gap_cnt == LOSS_TIMEOUT -> LOST.
  - The partial window is discarded with no MEAS_VALID.
- LOST:
  - CLK_LOST=1, FREQ_OK=0, FREQ_ERR=1.
  - Next edge_p -> MEASURE with that edge as the window start. CLK_LOST clears in the same transition.
  - FREQ_OK/FREQ_ERR keep the LOST values until the first full window completes.
- Simultaneous events:
  - edge_p in the same cycle gap_cnt would reach the timeout: the edge wins and there is no LOST transition.
  - EN falling in the terminal-edge cycle: IDLE wins; no MEAS_VALID; MEAS_COUNT is not updated.
- Reset mid-window: immediate clear, with no pulse on any output.
- Latency: MEAS_VALID arrives 3 + 1 CLK cycles after the terminal OSC_IN rise.

Decomposition:
- Shared package rcosc_mon_pkg:
  - FSM state enum.
  - Default constants: OSC_PERIODS, COUNT_W, EXP_MIN, EXP_MAX, LOSS_TIMEOUT.
  - Nominal CLK/OSC frequency constants used by the test bench.
- Sub-module osc_edge_sync: 2-FF synchroniser, delay FF and rising-edge pulse. It is reused by other async-input monitors.

Test Plan:
- Nominal: CLK 50 MHz, OSC_IN exactly 1 MHz, EN=1 -> first MEAS_VALID after 17 OSC rises; MEAS_COUNT=800, FREQ_OK=1, FREQ_ERR=0; subsequent windows every 800 cycles, back-to-back.
- Out of range:
  - OSC period 56 CLK cycles -> MEAS_COUNT=896, FREQ_ERR=1, FREQ_OK=0.
  - Period 47 -> MEAS_COUNT=752, FREQ_ERR=1.
  - Period 53 -> 848, FREQ_ERR=1.
  - Bounds exact: periods producing 760 and 840 -> FREQ_OK=1.
- Loss: stop OSC_IN mid-window -> CLK_LOST=1 exactly 200 cycles after the last edge_p; FREQ_ERR=1, no MEAS_VALID. Restart OSC -> CLK_LOST clears at the first edge_p, and a valid MEAS_VALID follows after 16 periods.
- Timeout race: OSC period set so edge_p lands in the cycle gap_cnt hits 200 -> no LOST entry; measurement continues.
- EN/reset: deassert EN at cycle 400 of a window -> IDLE next cycle, all flags 0, no MEAS_VALID; re-enable -> ARM then MEASURE. Assert RESETN low mid-window -> all outputs 0 asynchronously.
- Async robustness: OSC_IN edges with random phase relative to CLK (±1 cycle jitter) -> MEAS_COUNT stays within 800±1, no spurious double edge_p.

Source files
------------

// File: rtl/rcosc_mon_pkg.sv
// Shared types and default constants for the RC oscillator frequency monitor.
package rcosc_mon_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StLost} state_e;

  localparam int unsigned DEF_OSC_PERIODS  = 16;
  localparam int unsigned DEF_COUNT_W      = 16;
  localparam int unsigned DEF_EXP_MIN      = 760;
  localparam int unsigned DEF_EXP_MAX      = 840;
  localparam int unsigned DEF_LOSS_TIMEOUT = 200;

  localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
  localparam int unsigned OSC_FREQ_HZ         = 1_000_000;
  localparam int unsigned NOM_OSC_PERIOD_CLKS = CLK_FREQ_HZ / OSC_FREQ_HZ;

  function automatic logic in_window(input int unsigned val, input int unsigned lo,
                                     input int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser plus a delay flop; emits a one-cycle pulse per rising edge
// of an asynchronous input.
module osc_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  // r_sync[0], r_sync[1]: synchroniser; r_sync[2]: delayed copy for edge detection
  logic [2:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/rcosc_freq_monitor.sv
// Measures the RC oscillator against CLK over a fixed number of oscillator periods and
// flags in-range, out-of-range and lost-clock conditions.
module rcosc_freq_monitor
  import rcosc_mon_pkg::*;
#(
  parameter int unsigned OSC_PERIODS  = DEF_OSC_PERIODS,
  parameter int unsigned COUNT_W      = DEF_COUNT_W,
  parameter int unsigned EXP_MIN      = DEF_EXP_MIN,
  parameter int unsigned EXP_MAX      = DEF_EXP_MAX,
  parameter int unsigned LOSS_TIMEOUT = DEF_LOSS_TIMEOUT
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               EN,
  input  logic               OSC_IN,
  output logic [COUNT_W-1:0] MEAS_COUNT,
  output logic               MEAS_VALID,
  output logic               FREQ_OK,
  output logic               FREQ_ERR,
  output logic               CLK_LOST
);

  localparam int unsigned        EDGE_W    = $clog2(OSC_PERIODS + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_W-1:0] GAP_LIMIT = COUNT_W'(LOSS_TIMEOUT);
  localparam logic [EDGE_W-1:0]  EDGE_LAST = EDGE_W'(OSC_PERIODS - 1);

  state_e             r_state, w_state_d;
  logic [COUNT_W-1:0] r_win_cnt, w_win_d, r_gap_cnt, w_gap_d, r_meas_count, w_count_d;
  logic [EDGE_W-1:0]  r_edge_cnt, w_edge_d;
  logic               r_pend, w_pend_d, r_meas_valid, w_valid_d;
  logic               r_freq_ok, w_ok_d, r_freq_err, w_err_d;
  logic               w_edge, w_terminal, w_timeout;
  logic [COUNT_W-1:0] w_gap_inc, w_win_inc;

  osc_edge_sync u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_async (OSC_IN),
    .o_rise  (w_edge)
  );

  assign w_gap_inc  = (r_gap_cnt == CNT_MAX) ? r_gap_cnt : r_gap_cnt + COUNT_W'(1);
  assign w_win_inc  = (r_win_cnt == CNT_MAX) ? r_win_cnt : r_win_cnt + COUNT_W'(1);
  assign w_terminal = (r_state == StMeasure) && w_edge && (r_edge_cnt == EDGE_LAST);
  // An edge arriving in the timeout cycle wins over the loss transition
  assign w_timeout  = !w_edge && (w_gap_inc == GAP_LIMIT);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:           if (EN) w_state_d = StArm;
      StArm, StMeasure: begin
        if (w_edge)         w_state_d = StMeasure;
        else if (w_timeout) w_state_d = StLost;
      end
      StLost:           if (w_edge) w_state_d = StMeasure;
      default:          w_state_d = StIdle;
    endcase
    if (!EN) w_state_d = StIdle;
  end

  always_comb begin
    w_win_d   = r_win_cnt;
    w_edge_d  = r_edge_cnt;
    w_gap_d   = '0;
    w_count_d = r_meas_count;
    w_pend_d  = 1'b0;
    w_valid_d = 1'b0;
    w_ok_d    = r_freq_ok;
    w_err_d   = r_freq_err;
    if (w_state_d == StIdle) begin
      w_win_d  = '0;
      w_edge_d = '0;
      w_ok_d   = 1'b0;
      w_err_d  = 1'b0;
    end else if (w_state_d == StLost) begin
      w_ok_d  = 1'b0;
      w_err_d = 1'b1;
    end else begin
      if (r_pend) begin
        w_valid_d = 1'b1;
        w_ok_d    = in_window(32'(r_meas_count), EXP_MIN, EXP_MAX);
        w_err_d   = !w_ok_d;
      end
      if (w_edge) w_gap_d = COUNT_W'(1);
      else if (r_state == StArm || r_state == StMeasure) w_gap_d = w_gap_inc;
      if (w_edge && (r_state == StArm || r_state == StLost)) begin
        w_win_d  = COUNT_W'(1);
        w_edge_d = '0;
      end else if (r_state == StMeasure) begin
        w_win_d = w_win_inc;
        if (w_terminal) begin
          // Terminal edge doubles as the next window's start edge
          w_count_d = r_win_cnt;
          w_pend_d  = 1'b1;
          w_edge_d  = '0;
          w_win_d   = COUNT_W'(1);
        end else if (w_edge) begin
          w_edge_d = r_edge_cnt + EDGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_meas_count <= '0;
      r_pend       <= 1'b0;
      r_meas_valid <= 1'b0;
      r_freq_ok    <= 1'b0;
      r_freq_err   <= 1'b0;
    end else begin
      r_win_cnt    <= w_win_d;
      r_edge_cnt   <= w_edge_d;
      r_gap_cnt    <= w_gap_d;
      r_meas_count <= w_count_d;
      r_pend       <= w_pend_d;
      r_meas_valid <= w_valid_d;
      r_freq_ok    <= w_ok_d;
      r_freq_err   <= w_err_d;
    end
  end

  always_comb begin
    MEAS_COUNT = r_meas_count;
    MEAS_VALID = r_meas_valid;
    FREQ_OK    = r_freq_ok;
    FREQ_ERR   = r_freq_err;
    CLK_LOST   = (r_state == StLost);
  end

endmodule
